// File: rtl/frame_sink_checker_if.sv
// rtl/frame_sink_checker_if.sv - pixel stream handshake between video source and frame sink
interface frame_sink_checker_if;
    logic [23:0] in_pixel;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;

    modport master (output in_pixel, output in_valid, output in_last, input in_ready);
    modport slave  (input in_pixel, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/frame_sink_checker.sv
// rtl/frame_sink_checker.sv - pixel stream sink that checks the x/y test pattern; optional FRAME_SINK_CRC_EN adds a per-frame CRC-16
module frame_sink_checker #(
    parameter int          H_PIX   = 1280,
    parameter int          V_LINES = 720,
    parameter logic [15:0] BP_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_sink_checker_if.slave   s,
    input  logic                  bp_en,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [15:0]           frame_count,
    output logic [15:0]           err_count,
    output logic [15:0]           frame_crc
);

    typedef enum logic {ST_RUN, ST_RESYNC} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic [31:0] x_q, y_q;
    logic        frame_err_q;
    logic        err_q, end_q, ok_q;

    logic        accept;
    logic        at_x_end, at_f;
    logic [23:0] exp_pixel;
    logic        check_en, frame_end, pos_clear, pos_inc, beat_err;

    assign accept    = s.in_valid & s.in_ready;
    assign at_x_end  = (x_q == 32'(H_PIX - 1));
    assign at_f      = at_x_end && (y_q == 32'(V_LINES - 1));
    assign exp_pixel = {8'd0, x_q[7:0], y_q[7:0]};
    assign beat_err  = check_en & ((s.in_pixel != exp_pixel) | (s.in_last != at_f));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame ends on any accepted last in RUN, or at F without last (which then drops into RESYNC).
    always_comb begin
        state_d   = state_q;
        check_en  = 1'b0;
        frame_end = 1'b0;
        pos_clear = 1'b0;
        pos_inc   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    check_en = 1'b1;
                    if (s.in_last || at_f) begin
                        frame_end = 1'b1;
                        pos_clear = 1'b1;
                        if (!s.in_last) begin
                            state_d = ST_RESYNC;
                        end
                    end else begin
                        pos_inc = 1'b1;
                    end
                end
            end
            ST_RESYNC: begin
                if (accept && s.in_last) begin
                    pos_clear = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fibonacci LFSR, taps 16,14,13,11; its low two bits give ~75% ready duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= BP_SEED;
            s.in_ready <= 1'b0;
        end else begin
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            s.in_ready <= bp_en ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pos_clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pos_inc) begin
            if (at_x_end) begin
                x_q <= '0;
                y_q <= (y_q == 32'(V_LINES - 1)) ? '0 : y_q + 32'd1;
            end else begin
                x_q <= x_q + 32'd1;
            end
        end
    end

    // Beat results are captured on the accepting edge and published one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            err_q       <= 1'b0;
            end_q       <= 1'b0;
            ok_q        <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_err_q <= frame_end ? 1'b0 : (frame_err_q | beat_err);
            err_q       <= beat_err;
            end_q       <= frame_end;
            ok_q        <= ~(frame_err_q | beat_err);
            frame_done  <= end_q;
            if (end_q) begin
                frame_ok    <= ok_q;
                frame_count <= frame_count + 16'd1;
            end
            if (err_q && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

`ifdef FRAME_SINK_CRC_EN
    logic [15:0] crc_run_q, crc_end_q, crc_next;

    // CRC-16-CCITT over 24 bits, MSB first.
    function automatic logic [15:0] crc_step24(input logic [15:0] c_in, input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    assign crc_next = crc_step24(crc_run_q, s.in_pixel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_run_q <= 16'hFFFF;
            crc_end_q <= '0;
            frame_crc <= '0;
        end else begin
            if (frame_end) begin
                crc_run_q <= 16'hFFFF;
                crc_end_q <= crc_next;
            end else if (check_en) begin
                crc_run_q <= crc_next;
            end
            if (end_q) begin
                frame_crc <= crc_end_q;
            end
        end
    end
`else
    assign frame_crc = 16'd0;
`endif

endmodule

// File: doc/frame_sink_checker.md
# frame_sink_checker

Receive-side endpoint for the 24-bit pixel stream. It accepts a valid/ready pixel stream with an end-of-frame `last` marker and applies optional pseudo-random backpressure. It tracks raster position, checks every accepted beat against the deterministic test pattern `{8'd0, x[7:0], y[7:0]}` and the expected `last` placement, and reports per-frame pass/fail and error counters. It sits at the output of the video pipeline in the verification and bring-up path, as the consumer counterpart of the pattern generator.

## Interface
- `H_PIX`, 1280, active pixels per line (≥2)
- `V_LINES`, 720, lines per frame (≥2)
- `BP_SEED`, 16'hACE1, nonzero reset seed of the backpressure LFSR
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_pixel`  in  24  pixel data
- `in_valid`  in  1  source has a beat
- `in_last`  in  1  beat is final pixel of frame
- `in_ready`  out  1  sink accepts beat this cycle (registered)
- `bp_en`  in  1  enable pseudo-random backpressure
- `frame_done`  out  1  one-cycle pulse at end of each frame
- `frame_ok`  out  1  last completed frame had zero errors
- `frame_count`  out  16  completed frames, wraps
- `err_count`  out  16  erroneous beats, saturates at 16'hFFFF
- `frame_crc`  out  16  CRC of last completed frame (see Configuration)

## Operation
- Accept = `in_valid & in_ready`. Only accepted beats are checked or counted. `in_pixel` and `in_last` are ignored otherwise.
- Position counters `x` (0..H_PIX-1) and `y` (0..V_LINES-1), 32 bits each. On each accepted beat in RUN, x increments. At H_PIX-1, x wraps to 0 and y increments. At V_LINES-1, y wraps to 0.
- Expected pixel = `{8'd0, x[7:0], y[7:0]}`. Final position F is x=H_PIX-1, y=V_LINES-1.
- Per accepted beat in RUN, the beat is erroneous if any of the following holds. Each erroneous beat adds exactly +1 to `err_count`.
  - data mismatch;
  - `in_last`=1 at a position other than F (early last);
  - `in_last`=0 at F (missing last).
- A frame-error flag is set by any erroneous beat and cleared at each frame end.
- State machine:
  - RUN: normal checking.
    - Accepted beat with `in_last`=1, at any position: frame end. x and y go to 0; stay in RUN.
    - Accepted beat at F with `in_last`=0: frame end reported with `frame_ok`=0; go to RESYNC.
  - RESYNC: accepted beats are not checked, not counted and not CRC'd.
    - Accepted beat with `in_last`=1: x=y=0, go to RUN. No `frame_done` is emitted for this beat.
- Frame end effects, registered:
  - `frame_done`=1 for one cycle;
  - `frame_ok` = NOT(frame-error flag including the ending beat);
  - `frame_count`+1.
- Backpressure: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle after reset.
  - `bp_en`=0: next `in_ready`=1.
  - `bp_en`=1: next `in_ready` = `lfsr[0] | lfsr[1]`, about 75% duty.
- Reset values: `in_ready`=0, `frame_done`=0, `frame_ok`=0, `frame_count`=0, `err_count`=0, `frame_crc`=0, state=RUN, x=y=0, LFSR=BP_SEED.
- An asynchronous reset asserted mid-frame forces all outputs to their reset values immediately. Checking restarts at x=y=0 on the first accepted beat after release.

## Timing
- `in_ready` goes to 1 on the first rising edge after `rst` deasserts. It is always a registered output.
- The source must hold `in_pixel`, `in_valid` and `in_last` stable while `in_valid`=1 and `in_ready`=0. The block does not check this.
- `err_count` updates on the edge that follows the erroneous beat's accepting edge: 1-cycle latency.
- `frame_done`, `frame_ok`, `frame_count` and `frame_crc` all update on the same edge, one cycle after the frame-ending beat is accepted.
- Throughput: one beat per cycle when `bp_en`=0.
- `err_count` saturation and `frame_count` wrap (16'hFFFF→0) are evaluated on the same edge as the increment.

## Configuration
- Macro `FRAME_SINK_CRC_EN`.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) runs over all 24 bits of each accepted RUN beat, MSB first.
  - `frame_crc` latches the result at frame end.
  - The running CRC re-inits to 0xFFFF after each frame end and on reset.
- Undefined: the CRC logic is absent and `frame_crc` is tied to 0.

## Test plan
All scenarios use `H_PIX`=8, `V_LINES`=4 (32 beats per frame).
- Clean frame, `bp_en`=0, continuous valid, last on beat 31 → `frame_done` pulse 1 cycle after beat 31; `frame_ok`=1, `frame_count`=1, `err_count`=0.
- `bp_en`=1, source holds data while not ready, 3 frames → `in_ready` observed low at least once; `frame_count`=3, `err_count`=0. With the macro defined, all three `frame_crc` values are equal and nonzero. Without it, `frame_crc`=0.
- Beat 5 pixel sent as 24'h000501 instead of 24'h000500 → `err_count`=1, frame 1 `frame_ok`=0, next clean frame `frame_ok`=1.
- `in_last`=1 on beat 10 (x=2, y=1) → `err_count`=1, `frame_done` with `frame_ok`=0. The following beat is expected as 24'h000000 and passes.
- Beat 31 sent with `in_last`=0, then 5 garbage beats, the last of them with `in_last`=1 → `err_count`=1, one `frame_done` with `frame_ok`=0, garbage not counted. The next clean frame gives `frame_ok`=1 and `frame_count`=2.
- Assert `rst` asynchronously at beat 12 → all outputs at their reset values before the next edge. After release, a clean frame gives `frame_ok`=1 and `frame_count`=1.
